// File: rtl/signal_lamp_monitor.sv
// Lamp driver stage for the traffic controller: passes legal aspects to the
// lamps and falls back to flashing red on illegal or conflicting codes.
module signal_lamp_monitor #(
    parameter int BLINK_HALF     = 4,
    parameter int RECOVER_CYCLES = 8,
    parameter int FCNT_BITS      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           road1_in,
    input  logic [2:0]           road2_in,
    input  logic                 clear_fault,
    output logic [2:0]           road1_lamp,
    output logic [2:0]           road2_lamp,
    output logic                 fault,
    output logic [1:0]           fault_code,
    output logic [FCNT_BITS-1:0] fault_count
);

    localparam logic [2:0] RED  = 3'b001;
    localparam logic [2:0] DARK = 3'b000;

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int RW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_HALF - 1);
    localparam logic [RW-1:0] REC_MAX   = RW'(RECOVER_CYCLES - 1);

    typedef enum logic [1:0] {
        NORMAL,
        FAULT,
        RECOVER
    } state_t;

    state_t               state_q, state_d;
    logic [2:0]           lamp1_d, lamp2_d;
    logic                 fault_d;
    logic [1:0]           code_d;
    logic [FCNT_BITS-1:0] count_d, count_inc;
    logic [BW-1:0]        blink_q, blink_d;
    logic                 phase_q, phase_d;
    logic [RW-1:0]        rec_q, rec_d;

    logic illegal, conflict, err;

    always_comb begin
        illegal  = !$onehot(road1_in) || !$onehot(road2_in);
        conflict = (road1_in != RED) && (road2_in != RED);
        err      = illegal || conflict;
        count_inc = (fault_count == {FCNT_BITS{1'b1}}) ?
                    fault_count : fault_count + FCNT_BITS'(1);
    end

    always_comb begin
        state_d = state_q;
        lamp1_d = road1_lamp;
        lamp2_d = road2_lamp;
        code_d  = fault_code;
        count_d = fault_count;
        blink_d = blink_q;
        phase_d = phase_q;
        rec_d   = rec_q;

        unique case (state_q)
            NORMAL: begin
                if (err) begin
                    state_d = FAULT;
                    lamp1_d = RED;
                    lamp2_d = RED;
                    code_d  = {conflict, illegal};
                    count_d = count_inc;
                    blink_d = '0;
                    phase_d = 1'b1;
                end else begin
                    lamp1_d = road1_in;
                    lamp2_d = road2_in;
                end
            end
            FAULT: begin
                code_d = fault_code | {conflict, illegal};
                if (clear_fault && !err) begin
                    state_d = RECOVER;
                    rec_d   = '0;
                    lamp1_d = RED;
                    lamp2_d = RED;
                end else begin
                    if (blink_q == BLINK_MAX) begin
                        blink_d = '0;
                        phase_d = !phase_q;
                    end else begin
                        blink_d = blink_q + BW'(1);
                    end
                    lamp1_d = phase_d ? RED : DARK;
                    lamp2_d = phase_d ? RED : DARK;
                end
            end
            RECOVER: begin
                if (err) begin
                    state_d = FAULT;
                    lamp1_d = RED;
                    lamp2_d = RED;
                    code_d  = fault_code | {conflict, illegal};
                    count_d = count_inc;
                    blink_d = '0;
                    phase_d = 1'b1;
                end else if (rec_q == REC_MAX) begin
                    state_d = NORMAL;
                    lamp1_d = road1_in;
                    lamp2_d = road2_in;
                    code_d  = 2'b00;
                    rec_d   = '0;
                    blink_d = '0;
                    phase_d = 1'b1;
                end else begin
                    rec_d   = rec_q + RW'(1);
                    lamp1_d = RED;
                    lamp2_d = RED;
                end
            end
            default: state_d = NORMAL;
        endcase

        fault_d = (state_d != NORMAL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= NORMAL;
            road1_lamp  <= RED;
            road2_lamp  <= RED;
            fault       <= 1'b0;
            fault_code  <= 2'b00;
            fault_count <= '0;
            blink_q     <= '0;
            phase_q     <= 1'b1;
            rec_q       <= '0;
        end else begin
            state_q     <= state_d;
            road1_lamp  <= lamp1_d;
            road2_lamp  <= lamp2_d;
            fault       <= fault_d;
            fault_code  <= code_d;
            fault_count <= count_d;
            blink_q     <= blink_d;
            phase_q     <= phase_d;
            rec_q       <= rec_d;
        end
    end

endmodule

// File: tb/tb_signal_lamp_monitor.sv
// Bench for signal_lamp_monitor: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a behavioural model.
module tb_signal_lamp_monitor;

    localparam int BH = 4;
    localparam int RC = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] r1 = 3'b001;
    logic [2:0] r2 = 3'b001;
    logic       clr = 1'b0;

    logic [2:0] l1, l2, s_l1, s_l2;
    logic       flt, s_flt;
    logic [1:0] code, s_code;
    logic [7:0] cnt;
    logic [1:0] s_cnt;

    int total = 0;
    int bad   = 0;

    // model: mode 0 = lamps follow, 1 = flashing, 2 = waiting out recovery
    int         m_mode, m_age, m_rec, m_cnt;
    logic [2:0] m_l1, m_l2;
    logic [1:0] m_code;

    always #5 clk = ~clk;

    signal_lamp_monitor #(.BLINK_HALF(BH), .RECOVER_CYCLES(RC),
                          .FCNT_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .road1_in(r1), .road2_in(r2),
        .clear_fault(clr), .road1_lamp(l1), .road2_lamp(l2),
        .fault(flt), .fault_code(code), .fault_count(cnt)
    );

    signal_lamp_monitor #(.BLINK_HALF(BH), .RECOVER_CYCLES(RC),
                          .FCNT_BITS(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .road1_in(r1), .road2_in(r2),
        .clear_fault(clr), .road1_lamp(s_l1), .road2_lamp(s_l2),
        .fault(s_flt), .fault_code(s_code), .fault_count(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_age = 0; m_rec = 0; m_cnt = 0;
            m_l1 = 3'b001; m_l2 = 3'b001; m_code = 2'b00;
        end else begin
            bit il, cf, e;
            il = ($countones(r1) != 1) || ($countones(r2) != 1);
            cf = (r1 != 3'b001) && (r2 != 3'b001);
            e  = il || cf;
            if (m_mode == 0) begin
                if (e) begin
                    m_mode = 1; m_age = 0; m_cnt++;
                    m_code = {cf, il};
                    m_l1 = 3'b001; m_l2 = 3'b001;
                end else begin
                    m_l1 = r1; m_l2 = r2;
                end
            end else if (m_mode == 1) begin
                m_code = m_code | {cf, il};
                if (clr && !e) begin
                    m_mode = 2; m_rec = 0;
                    m_l1 = 3'b001; m_l2 = 3'b001;
                end else begin
                    m_age++;
                    m_l1 = ((m_age / BH) % 2 == 0) ? 3'b001 : 3'b000;
                    m_l2 = m_l1;
                end
            end else begin
                if (e) begin
                    m_mode = 1; m_age = 0; m_cnt++;
                    m_code = m_code | {cf, il};
                    m_l1 = 3'b001; m_l2 = 3'b001;
                end else begin
                    m_rec++;
                    if (m_rec == RC) begin
                        m_mode = 0; m_code = 2'b00;
                        m_l1 = r1; m_l2 = r2;
                    end else begin
                        m_l1 = 3'b001; m_l2 = 3'b001;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("lamp1", l1, m_l1);
            chk("lamp2", l2, m_l2);
            chk("fault", flt, m_mode != 0);
            chk("code", code, m_code);
            chk("count", cnt, (m_cnt > 255) ? 255 : m_cnt);
            chk("sat_lamp1", s_l1, m_l1);
            chk("sat_fault", s_flt, m_mode != 0);
            chk("sat_count", s_cnt, (m_cnt > 3) ? 3 : m_cnt);
        end
    end

    task automatic step(input logic [2:0] a, input logic [2:0] b,
                        input logic c);
        r1 = a; r2 = b; clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] legal [5];
        legal[0] = 6'b001_001; legal[1] = 6'b001_100;
        legal[2] = 6'b001_010; legal[3] = 6'b100_001;
        legal[4] = 6'b010_001;

        #12;
        chk("rst_lamp1", l1, 3'b001);
        chk("rst_lamp2", l2, 3'b001);
        chk("rst_fault", flt, 0);
        chk("rst_code", code, 0);
        chk("rst_count", cnt, 0);
        #5 rst_n = 1'b1;

        step(3'b010, 3'b001, 0);
        chk("pass_y_r", {l1, l2}, 6'b010_001);
        step(3'b100, 3'b001, 0);
        chk("pass_g_r", {l1, l2}, 6'b100_001);
        step(3'b001, 3'b010, 0);
        chk("pass_r_y", {l1, l2}, 6'b001_010);
        chk("pass_fault", flt, 0);

        step(3'b100, 3'b100, 0);
        chk("gg_fault", flt, 1);
        chk("gg_code", code, 2'b10);
        chk("gg_count", cnt, 1);
        chk("gg_lamps", {l1, l2}, 6'b001_001);
        repeat (3) step(3'b001, 3'b001, 0);
        chk("flash_on_end", {l1, l2}, 6'b001_001);
        step(3'b001, 3'b001, 0);
        chk("flash_off", {l1, l2}, 6'b000_000);

        step(3'b011, 3'b001, 1);
        chk("clr_ignored", flt, 1);
        chk("code_or", code, 2'b11);
        chk("still_off", {l1, l2}, 6'b000_000);
        step(3'b001, 3'b100, 1);
        chk("recover_lamps", {l1, l2}, 6'b001_001);
        chk("recover_fault", flt, 1);
        repeat (5) step(3'b001, 3'b100, 0);
        step(3'b000, 3'b001, 0);
        chk("refault_count", cnt, 2);
        chk("refault_code", code, 2'b11);
        chk("refault_on", {l1, l2}, 6'b001_001);

        step(3'b001, 3'b100, 1);
        repeat (7) step(3'b001, 3'b100, 0);
        chk("rec_last", flt, 1);
        step(3'b001, 3'b100, 0);
        chk("normal_fault", flt, 0);
        chk("normal_code", code, 0);
        chk("normal_lamps", {l1, l2}, 6'b001_100);

        repeat (5) begin
            step(3'b100, 3'b100, 0);
            step(3'b001, 3'b001, 1);
        end
        chk("count7", cnt, 7);
        chk("sat3", s_cnt, 2'd3);

        step(3'b100, 3'b010, 0);
        repeat (4) step(3'b001, 3'b001, 0);
        chk("pre_rst_off", {l1, l2}, 6'b000_000);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_lamps", {l1, l2}, 6'b001_001);
        chk("arst_fault", flt, 0);
        chk("arst_code", code, 0);
        chk("arst_count", cnt, 0);
        chk("arst_sat", s_cnt, 0);
        #2 rst_n = 1'b1;
        step(3'b010, 3'b001, 0);
        chk("post_rst_pass", {l1, l2}, 6'b010_001);
        chk("post_rst_fault", flt, 0);

        for (int i = 0; i < 3000; i++) begin
            logic [5:0] p;
            if ($urandom_range(0, 9) == 0)
                p = 6'($urandom);
            else
                p = legal[$urandom_range(0, 4)];
            step(p[5:3], p[2:0], $urandom_range(0, 3) == 0);
            if (i == 1500) begin
                #2 rst_n = 1'b0;
                #1 chk("rand_arst", {l1, l2, flt}, 7'b001_001_0);
                #2 rst_n = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
